// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the core and a 128-bit block memory.
// Define DCACHE_STATS_EN to add the hit_count/miss_count outputs.
module dcache_controller #(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned TAG_BITS   = 28 - INDEX_BITS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  address,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  output logic         busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_address,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned LINE_BITS = 128;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

  state_t                    state;
  logic [LINES-1:0]          valid;
  logic [LINES-1:0]          dirty;
  logic [TAG_BITS-1:0]       tags [LINES];
  logic [LINE_BITS-1:0]      data [LINES];
  logic [TAG_BITS-1:0]       miss_tag;
  logic [INDEX_BITS-1:0]     miss_idx;
  logic                      started;

  logic [INDEX_BITS-1:0]     idx;
  logic [TAG_BITS-1:0]       tag;
  logic [1:0]                woff;
  logic                      access;
  logic                      hit;
  logic                      idle_hit;
  logic                      xfer_done;
  logic                      unused_addr_bits;

  assign idx    = address[4+INDEX_BITS-1:4];
  assign tag    = TAG_BITS'(address[31:4+INDEX_BITS]);
  assign woff   = address[3:2];
  assign access = read ^ write;
  assign hit    = valid[idx] && (tags[idx] == tag);
  assign idle_hit = (state == IDLE) && hit;
  assign unused_addr_bits = ^address[1:0];

  assign busywait = access && !idle_hit;
  assign readdata = (idle_hit && read && !write) ? data[idx][{woff, 5'b0} +: 32] : 32'h0;

  // A transfer may only complete once the request has been visible for a full cycle.
  assign xfer_done = (mem_read || mem_write) && started && !mem_busywait;

  // Control state, line status and memory-side request registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      miss_tag      <= '0;
      miss_idx      <= '0;
      started       <= 1'b0;
    end else begin
      started <= (mem_read || mem_write) && !xfer_done;
      case (state)
        IDLE: begin
          if (access) begin
            if (hit) begin
              if (write) dirty[idx] <= 1'b1;
            end else begin
              miss_tag <= tag;
              miss_idx <= idx;
              if (valid[idx] && dirty[idx]) begin
                state         <= WRITEBACK;
                mem_write     <= 1'b1;
                mem_address   <= 28'({tags[idx], idx});
                mem_writedata <= data[idx];
              end else begin
                state       <= ALLOCATE;
                mem_read    <= 1'b1;
                mem_address <= 28'({tag, idx});
              end
            end
          end
        end
        WRITEBACK: begin
          if (xfer_done) begin
            mem_write <= 1'b0;
            state     <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          // Entered from WRITEBACK with the request low: raise it one cycle later.
          if (!mem_read) begin
            mem_read    <= 1'b1;
            mem_address <= 28'({miss_tag, miss_idx});
          end else if (xfer_done) begin
            mem_read <= 1'b0;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          valid[miss_idx] <= 1'b1;
          dirty[miss_idx] <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line data and tags carry no reset; valid bits qualify them.
  always_ff @(posedge clock) begin
    if (reset) begin
      if ((state == IDLE) && write && !read && hit) begin
        data[idx][{woff, 5'b0} +: 32] <= writedata;
      end
      if (state == UPDATE) begin
        data[miss_idx] <= mem_readdata;
        tags[miss_idx] <= miss_tag;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else if ((state == IDLE) && access) begin
      if (hit) hit_count  <= hit_count + 32'h1;
      else     miss_count <= miss_count + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios, then random traffic
// checked against a flat word-memory model and a residency table.
module tb_dcache_controller;

  localparam int LIMIT = 200;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  dcache_controller dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural block memory.
  logic [127:0] dev_mem [logic [27:0]];
  logic         mem_active = 1'b0;
  int           mem_cnt    = 0;
  int           fixed_lat  = 3;
  logic         rand_lat   = 1'b0;

  function automatic logic [31:0] init_word(input logic [27:0] blk, input logic [1:0] w);
    return {blk[13:0], w, 16'hC0DE};
  endfunction

  function automatic logic [127:0] dev_line(input logic [27:0] blk);
    if (dev_mem.exists(blk)) return dev_mem[blk];
    return {init_word(blk, 2'd3), init_word(blk, 2'd2), init_word(blk, 2'd1), init_word(blk, 2'd0)};
  endfunction

  always @(negedge clock) begin
    if (!mem_active) begin
      if (mem_read || mem_write) begin
        mem_active   = 1'b1;
        mem_busywait = 1'b1;
        mem_cnt      = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
      end
    end else if (!(mem_read || mem_write)) begin
      mem_active   = 1'b0;
      mem_busywait = 1'b0;
    end else if (mem_cnt > 0) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        if (mem_write) dev_mem[mem_address] = mem_writedata;
        else           mem_readdata = dev_line(mem_address);
        mem_busywait = 1'b0;
      end
    end
  end

  // Reference: what the core should see, plus which block each index holds.
  logic [31:0] ref_word [logic [29:0]];
  logic        res_v [8];
  logic        res_d [8];
  logic [27:0] res_blk [8];
  int          ref_hits;
  int          ref_misses;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_word.exists(a[31:2])) return ref_word[a[31:2]];
    return init_word(a[31:4], a[3:2]);
  endfunction

  function automatic logic [127:0] ref_line(input logic [27:0] blk);
    logic [31:0] base;
    base = {blk, 4'h0};
    return {ref_rd(base + 32'hC), ref_rd(base + 32'h8), ref_rd(base + 32'h4), ref_rd(base)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic         seen_wr, seen_rd;
  logic [27:0]  wr_addr, rd_addr;
  logic [127:0] wr_data;

  // Issue one request at posedge+1; returns data sampled when busywait falls and the stall count.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdat, output int stalls);
    read = rd; write = wr; address = a; writedata = wd;
    stalls = 0; seen_wr = 1'b0; seen_rd = 1'b0;
    @(negedge clock);
    while (busywait && stalls < LIMIT) begin
      if (mem_write && !seen_wr) begin seen_wr = 1'b1; wr_addr = mem_address; wr_data = mem_writedata; end
      if (mem_read && !seen_rd)  begin seen_rd = 1'b1; rd_addr = mem_address; end
      stalls++;
      @(negedge clock);
    end
    chk("no_timeout", 128'(stalls < LIMIT), 128'(1));
    rdat = readdata;
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
  endtask

  // Perform an access and check it against the reference; exp_stalls < 0 skips exact timing.
  task automatic run(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input int exp_stalls);
    logic [31:0] rdat;
    int          st;
    logic [27:0] blk;
    int          ix;
    logic        hit_e, vic_dirty;
    blk = a[31:4];
    ix  = int'(a[6:4]);
    hit_e     = res_v[ix] && (res_blk[ix] == blk);
    vic_dirty = res_v[ix] && res_d[ix] && !hit_e;
    access(rd, wr, a, wd, rdat, st);
    chk("hit_nostall", 128'(st == 0), 128'(hit_e));
    if (exp_stalls >= 0) chk("stall_cycles", 128'(st), 128'(exp_stalls));
    if (rd) chk("readdata", 128'(rdat), 128'(ref_rd(a)));
    chk("wb_seen", 128'(seen_wr), 128'(vic_dirty));
    if (vic_dirty) begin
      chk("wb_addr", 128'(wr_addr), 128'(res_blk[ix]));
      chk("wb_data", wr_data, ref_line(res_blk[ix]));
    end
    chk("fill_seen", 128'(seen_rd), 128'(!hit_e));
    if (!hit_e) begin
      chk("fill_addr", 128'(rd_addr), 128'(blk));
      ref_misses++;
      res_v[ix] = 1'b1; res_d[ix] = 1'b0; res_blk[ix] = blk;
    end
    ref_hits++;
    if (wr) begin
      ref_word[a[31:2]] = wd;
      res_d[ix] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] a, wd, rdat;
    logic        wr;
    int          st;
    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    for (int i = 0; i < 8; i++) begin res_v[i] = 1'b0; res_d[i] = 1'b0; res_blk[i] = '0; end
    ref_hits = 0; ref_misses = 0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busywait", 128'(busywait), 128'(0));
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mem_address", 128'(mem_address), 128'(0));
    chk("rst_mem_writedata", mem_writedata, 128'(0));
    chk("rst_readdata", 128'(readdata), 128'(0));
    reset = 1'b1;
    @(posedge clock); #1;

    // Clean miss, then store and load on the resident line.
    run(1'b1, 1'b0, 32'h0000_0040, 32'h0, 6);
    run(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0);
    run(1'b1, 1'b0, 32'h0000_0044, 32'h0, 0);
    chk("read_back_44", 128'(ref_rd(32'h44)), 128'(32'hDEAD_BEEF));
`ifdef DCACHE_STATS_EN
    chk("stats_hit", 128'(hit_count), 128'(3));
    chk("stats_miss", 128'(miss_count), 128'(1));
`endif

    // Conflict miss on index 4 evicts the dirty line first.
    run(1'b1, 1'b0, 32'h0000_00C4, 32'h0, 11);
    chk("wb_word1", 128'(wr_data[63:32]), 128'(32'hDEAD_BEEF));
    chk("wb_addr_4", 128'(wr_addr), 128'(28'h4));
    chk("fill_addr_C", 128'(rd_addr), 128'(28'hC));
    chk("mem_has_evicted", dev_line(28'h4), {init_word(28'h4, 2'd3), init_word(28'h4, 2'd2),
                                             32'hDEAD_BEEF, init_word(28'h4, 2'd0)});

    // Simultaneous read and write: no access at all.
    read = 1'b1; write = 1'b1; address = 32'h0000_00C4; writedata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("both_busywait", 128'(busywait), 128'(0));
      chk("both_no_mem", 128'({mem_read, mem_write}), 128'(0));
    end
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
    run(1'b1, 1'b0, 32'h0000_00C4, 32'h0, 0);

    // Reset while ALLOCATE is in flight.
    read = 1'b1; address = 32'h0000_0104;
    st = 0;
    @(negedge clock);
    while (!mem_read && st < LIMIT) begin st++; @(negedge clock); end
    chk("alloc_started", 128'(mem_read), 128'(1));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_mid_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mid_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mid_busywait", 128'(busywait), 128'(1));
    read = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) res_v[i] = 1'b0;
    ref_hits = 0; ref_misses = 0;
    @(posedge clock); #1;
    run(1'b1, 1'b0, 32'h0000_0104, 32'h0, 6);
    run(1'b1, 1'b0, 32'h0000_00C4, 32'h0, 6);

    // Random traffic over four tags per index with random memory latency.
    rand_lat = 1'b1;
    for (int k = 0; k < 250; k++) begin
      a  = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4)
         | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      run(!wr, wr, a, wd, -1);
    end
`ifdef DCACHE_STATS_EN
    chk("stats_hit_final", 128'(hit_count), 128'(ref_hits));
    chk("stats_miss_final", 128'(miss_count), 128'(ref_misses));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache placed between the RISC-V core's load/store stage and the 128-bit block-transfer data memory. Serves 32-bit word accesses from a local line array; on a miss it acts as the initiator of the memory's read/write/busywait protocol, evicting a dirty line before fetching the new one. Stalls the core through `busywait` until the access can complete.

## Interface
- `INDEX_BITS`, 3: line index width; `2**INDEX_BITS` lines of 16 bytes each.
- `TAG_BITS`, 28-INDEX_BITS: tag width (block address = `{tag, index}`, 28 bits).

- `clock`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-low: sampled at the rising edge of `clock`; `reset==0` resets.
- `read`  in  1  core load request, level, held until `busywait` low.
- `write`  in  1  core store request, level, held until `busywait` low.
- `address`  in  32  byte address; [3:2] word offset, [1:0] ignored.
- `writedata`  in  32  store data.
- `readdata`  out  32  load data, valid when `read` && !`busywait`.
- `busywait`  out  1  core stall.
- `mem_read`  out  1  memory block read request.
- `mem_write`  out  1  memory block write request.
- `mem_address`  out  28  memory block address.
- `mem_writedata`  out  128  evicted line, byte 0 in [7:0].
- `mem_readdata`  in  128  fetched line.
- `mem_busywait`  in  1  memory busy.

## Operation
- Per line: valid, dirty, tag, 128-bit data. Hit = valid && tag match, index = `address[4+INDEX_BITS-1:4]`, tag = `address[31:4+INDEX_BITS]` truncated to TAG_BITS.
- `read && write` both high: no access, `busywait=0`, no state change.
- States: IDLE, WRITEBACK, ALLOCATE, UPDATE.
- IDLE, hit: read returns word `address[3:2]` combinationally; write merges 32-bit word into line at the rising edge, sets dirty. Stay IDLE.
- IDLE, miss, victim clean or invalid -> ALLOCATE; victim valid && dirty -> WRITEBACK.
- WRITEBACK: `mem_write=1`, `mem_address={victim tag, index}`, `mem_writedata`=victim line; on completion -> ALLOCATE.
- ALLOCATE: `mem_read=1`, `mem_address={new tag, index}`; on completion -> UPDATE.
- UPDATE: one cycle; latch `mem_readdata` into line, valid=1, dirty=0, tag=new tag; -> IDLE, where the request now hits and completes normally (writes then set dirty).
- Completion: rising edge at which request is asserted and `mem_busywait==0`, no earlier than the second cycle of the request. Request, address and writedata held stable until then; request deasserted on the following edge so the memory sees read/write drop between transfers.
- Request dropped by core mid-miss: in-flight transfer still completes; line still updated.

## Timing
- `busywait` combinational: `(read ^ write) && !(state==IDLE && hit)`.
- `readdata` = selected word when read hit in IDLE, else 32'h0.
- Reset values: state IDLE, all valid/dirty 0, `mem_read=0`, `mem_write=0`, `mem_address=0`, `mem_writedata=0`; `busywait`/`readdata` follow from the above.
- Hit latency 0 stall cycles. Clean miss: 1 (IDLE->ALLOCATE) + N memory cycles + 1 UPDATE + hit. Dirty miss adds WRITEBACK's N cycles. With the 16-cycle block memory, clean miss ≈ 18, dirty ≈ 34 stall cycles.
- Reset mid-transfer: state to IDLE and `mem_read`/`mem_write` to 0 at that edge; no line updated; lines invalidated.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `hit_count` and `miss_count` (32 bits each, reset 0, wrap at 2^32). `hit_count` increments once per completed hit access (including the post-UPDATE hit); `miss_count` once per IDLE->WRITEBACK/ALLOCATE transition.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, then read 0x0000_0040 -> `busywait=1`, `mem_read=1`, `mem_address=28'h4`; after memory completes, UPDATE, then `readdata`=memory word at 0x40, `busywait=0`.
- Write 0xDEADBEEF to 0x44 (line present) -> zero stall; read 0x44 -> 0xDEADBEEF immediately; no memory request.
- Access 0x0000_00C4 (same index 4, different tag) after dirty write -> `mem_write=1`, `mem_address=28'h4`, `mem_writedata[63:32]=0xDEADBEEF`; then `mem_read` with `mem_address=28'hC`.
- `read=1, write=1` simultaneously -> `busywait=0`, no memory request, no line change.
- Reset (`reset=0`) during ALLOCATE -> next edge `mem_read=0`, state IDLE; re-read same address misses again.
- With `DCACHE_STATS_EN`: one clean miss then two hits to same line -> `miss_count=1`, `hit_count=3`.
